div_nr: RTL and testbench
=========================

# div_nr

Iterative non-restoring integer divider for the ALU datapath: accepts a dividend/divisor pair on a start pulse, produces quotient and remainder after a fixed number of cycles, and signals completion with a one-cycle ready pulse. It is the multi-cycle counterpart to the single-cycle add/subtract unit, built around one add/sub step per clock. It sits beside the ALU and is stalled-on by the pipeline via `busy`.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width in bits.

- `clk`  in  1: clock, all state updates on rising edge.
- `clrn`  in  1: asynchronous active-low reset.
- `start`  in  1: request; accepted only on an edge where `busy`=0.
- `a`  in  WIDTH: dividend, sampled on the accepting edge.
- `b`  in  WIDTH: divisor, sampled on the accepting edge.
- `sign`  in  1: signed operation select; present only with `DIV_NR_SIGNED_EN`.
- `q`  out  WIDTH: quotient, held until the next completion.
- `r`  out  WIDTH: remainder, held until the next completion.
- `busy`  out  1: operation in progress; new `start` ignored.
- `ready`  out  1: one-cycle pulse, `q`/`r`/`div_zero` valid.
- `div_zero`  out  1: last completed operation had `b`=0; held with `q`/`r`.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1: latch operands, `busy`←1. If `b`=0, the result is written directly (see below) and the FSM stays in IDLE. Otherwise, go to RUN with iteration counter `cnt`=0.
- RUN: WIDTH iterations. Each iteration shifts the partial remainder `pr` (WIDTH+1 bits, signed) left by one, bringing in the next dividend MSB.
  - If `pr` ≥ 0: subtract the divisor. Otherwise: add the divisor.
  - The quotient bit is the inverted sign of the new `pr`.
  - `cnt` increments; after iteration WIDTH-1, go to FIX.
- FIX: if `pr` < 0, `r` = `pr` + divisor; otherwise `r` = `pr`. `q` is the assembled quotient. Then `busy`←0, `ready`←1, `div_zero`←0, and return to IDLE.
- Divide-by-zero: `q`=all ones, `r`=`a`, `div_zero`=1, `ready`=1. No iterations are performed.
- Arithmetic is unsigned (WIDTH-bit magnitudes) unless `DIV_NR_SIGNED_EN` is defined.
- `start` while `busy`=1 is ignored; no queuing, and the operands in flight are unaffected.
- Reset values: `q`=0, `r`=0, `busy`=0, `ready`=0, `div_zero`=0, state IDLE, `cnt`=0.
- `clrn` asserted mid-operation aborts the operation. No `ready` pulse is produced for it.

## Timing
- Accepting edge E0: `busy`=1 after E0.
- Normal operation:
  - Iterations occur on edges E1..E32 (E1..E_WIDTH).
  - FIX occurs on edge E_WIDTH+1.
  - `ready`=1 and `busy`=0 during the cycle after E_WIDTH+1. Latency is WIDTH+1 edges (33 at default).
- Divide-by-zero: results and `ready` are updated on E0 itself. `busy` never rises.
- `ready` drops on the following edge.
- A new `start` may be asserted in the same cycle `ready`=1; it is accepted because `busy`=0.
- Back-to-back throughput is one result per WIDTH+2 cycles.

## Configuration
- `DIV_NR_SIGNED_EN` defined:
  - Adds the `sign` port. With `sign`=1, operands are two's complement.
  - Magnitudes are taken at E0 and divided unsigned.
  - In FIX, `q` is negated if the operand signs differ, and `r` takes the dividend's sign.
  - Most-negative ÷ -1 gives `q`=most-negative, `r`=0.
  - Divide-by-zero gives `q`=all ones, `r`=`a`.
  - Latency is unchanged.
- Not defined: the `sign` port is absent and all operations are unsigned.

## Structure
- Package `div_nr_pkg`:
  - state enum {IDLE, RUN, FIX};
  - default WIDTH constant;
  - counter width `$clog2(WIDTH)`.
- One sub-module `div_nr_step`, combinational:
  - inputs: `pr`, divisor, incoming dividend bit;
  - outputs: next `pr` and the quotient bit, via a single add/sub selected by the `pr` sign.
- The top level holds the FSM, counter, operand/quotient shift register and sign fixup.

## Test plan
- `a`=100, `b`=7, unsigned → `q`=14, `r`=2, `ready` exactly 33 cycles after the accepting edge, `busy` high for 33 cycles.
- `a`=0x0000_1234, `b`=0 → `q`=0xFFFF_FFFF, `r`=0x1234, `div_zero`=1, `ready` on the cycle after start, `busy` stays 0.
- Edge values, unsigned:
  - `a`=0xFFFF_FFFF, `b`=1 → `q`=0xFFFF_FFFF, `r`=0;
  - `a`=5, `b`=9 → `q`=0, `r`=5.
- `a`=100, `b`=7 started, then `start` with `a`=50, `b`=5 at cycle 10 → ignored; result is `q`=14, `r`=2.
- `clrn` pulsed low at cycle 10 of a run → all outputs 0 immediately, no `ready`. A fresh `a`=9, `b`=3 then yields `q`=3, `r`=0.
- With `DIV_NR_SIGNED_EN`, `sign`=1:
  - -7 / 2 → `q`=0xFFFF_FFFD, `r`=0xFFFF_FFFF;
  - 0x8000_0000 / 0xFFFF_FFFF → `q`=0x8000_0000, `r`=0.

Source files
------------

// File: rtl/div_nr_pkg.sv
// div_nr_pkg: shared types and constants for the iterative non-restoring divider.
//   state_t       : controller states IDLE / RUN / FIX
//   DIV_NR_WIDTH  : default operand width
//   DIV_NR_CNT_W  : iteration counter width for the default operand width
package div_nr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DIV_NR_WIDTH = 32;
  localparam int DIV_NR_CNT_W = $clog2(DIV_NR_WIDTH);

endpackage

// File: rtl/div_nr_step.sv
// div_nr_step: one non-restoring division iteration (combinational).
//   pr      in  WIDTH+1 : signed partial remainder before this iteration
//   d       in  WIDTH   : divisor magnitude
//   din     in  1       : next dividend bit shifted into the partial remainder
//   pr_next out WIDTH+1 : partial remainder after the add/subtract
//   q_bit   out 1       : quotient bit (1 when the new partial remainder is >= 0)
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   pr,
  input  logic [WIDTH-1:0] d,
  input  logic             din,
  output logic [WIDTH:0]   pr_next,
  output logic             q_bit
);

  logic             sub;
  logic [WIDTH:0]   pr_sh;
  logic [WIDTH:0]   d_ext;

  // A non-negative remainder subtracts the divisor, a negative one adds it back.
  assign sub   = ~pr[WIDTH];
  // The top bit is dropped by the shift; arithmetic is modulo 2^(WIDTH+1) and the
  // result always lands in [-d, d), which fits the signed WIDTH+1 range.
  assign pr_sh = {pr[WIDTH-1:0], din};
  assign d_ext = {1'b0, d};

  // Single adder: subtraction as add of the inverted divisor plus one.
  assign pr_next = pr_sh + (d_ext ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
  assign q_bit   = ~pr_next[WIDTH];

endmodule

// File: rtl/div_nr.sv
// div_nr: iterative non-restoring integer divider, one add/sub step per clock.
//   clk      in  1     : clock, rising edge
//   clrn     in  1     : asynchronous active-low reset
//   start    in  1     : request, accepted only when busy=0
//   a        in  WIDTH : dividend, sampled on the accepting edge
//   b        in  WIDTH : divisor, sampled on the accepting edge
//   sign     in  1     : signed operation select (only with DIV_NR_SIGNED_EN)
//   q        out WIDTH : quotient, held until the next completion
//   r        out WIDTH : remainder, held until the next completion
//   busy     out 1     : operation in progress
//   ready    out 1     : one-cycle completion pulse
//   div_zero out 1     : last completed operation had b=0
// Optional feature macro: DIV_NR_SIGNED_EN adds the sign port and two's complement
// operation (magnitudes divided unsigned, signs fixed up at the end).
//
// Handshake: start is a request sampled on a rising edge; it is taken only when
// busy=0 on that edge, otherwise it is dropped (no queuing). ready pulses for
// exactly one cycle when q/r/div_zero update; a start in that same cycle is
// accepted because busy is already low. Divide-by-zero completes on the accepting
// edge itself and never raises busy.
module div_nr
  import div_nr_pkg::*;
#(
  parameter int WIDTH = DIV_NR_WIDTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_NR_SIGNED_EN
  input  logic             sign,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   pr;
  // qa starts as the dividend; each iteration shifts a dividend bit out of the
  // top and a quotient bit into the bottom, so it ends holding the quotient.
  logic [WIDTH-1:0] qa;
  logic [WIDTH-1:0] dv;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_q_in;
  logic             neg_r_in;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   pr_next;
  logic             q_bit;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef DIV_NR_SIGNED_EN
  logic a_neg;
  logic b_neg;
  assign a_neg    = sign & a[WIDTH-1];
  assign b_neg    = sign & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  // Quotient is negative when operand signs differ; remainder follows the dividend.
  assign neg_q_in = a_neg ^ b_neg;
  assign neg_r_in = a_neg;
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign neg_q_in = 1'b0;
  assign neg_r_in = 1'b0;
`endif

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr),
    .d       (dv),
    .din     (qa[WIDTH-1]),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // Final correction: a negative partial remainder is restored by one add.
  assign r_mag = pr[WIDTH] ? (pr[WIDTH-1:0] + dv) : pr[WIDTH-1:0];
  // Most-negative / -1 wraps naturally: magnitude 2^(WIDTH-1) negates to itself.
  assign q_fix = neg_q ? -qa : qa;
  assign r_fix = neg_r ? -r_mag : r_mag;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      cnt      <= '0;
      pr       <= '0;
      qa       <= '0;
      dv       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              q        <= '1;
              r        <= a;
              div_zero <= 1'b1;
              ready    <= 1'b1;
            end else begin
              busy  <= 1'b1;
              cnt   <= '0;
              pr    <= '0;
              qa    <= a_mag;
              dv    <= b_mag;
              neg_q <= neg_q_in;
              neg_r <= neg_r_in;
              state <= RUN;
            end
          end
        end
        RUN: begin
          pr  <= pr_next;
          qa  <= {qa[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          q        <= q_fix;
          r        <= r_fix;
          busy     <= 1'b0;
          ready    <= 1'b1;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_nr.sv
// tb_div_nr: self-checking bench for div_nr with a reference model based on
// plain integer division.
module tb_div_nr;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef DIV_NR_SIGNED_EN
  logic         sign = 1'b0;
`endif
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         ready;
  logic         div_zero;

  int n_tests = 0;
  int n_fail  = 0;
  // Expected results, pushed as quotient then remainder.
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  div_nr #(.WIDTH(W)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef DIV_NR_SIGNED_EN
    .sign     (sign),
`endif
    .q        (q),
    .r        (r),
    .busy     (busy),
    .ready    (ready),
    .div_zero (div_zero)
  );

  // ---------------- reference model ----------------
  function automatic void predict(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic sg);
    longint sx;
    longint sy;
    longint qq;
    longint rr;
    if (y == '0) begin
      exp_q.push_back('1);
      exp_q.push_back(x);
    end else if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      qq = sx / sy;
      rr = sx % sy;
      exp_q.push_back(qq[W-1:0]);
      exp_q.push_back(rr[W-1:0]);
    end else begin
      exp_q.push_back(x / y);
      exp_q.push_back(x % y);
    end
  endfunction

  // ---------------- drivers ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge E0.
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until ready is seen. At sample index poke_at a second
  // start (50 / 5) is driven for one edge to check that it is ignored.
  task automatic wait_done(input int poke_at, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (ready !== 1'b1 && lat <= 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat == poke_at) begin
        a = 50;
        b = 5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (lat > 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: ready not seen within %0d edges", lat);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (q !== '0) begin n_fail++; $display("FAIL reset_q: got %h want 0", q); end
    n_tests++;
    if (r !== '0) begin n_fail++; $display("FAIL reset_r: got %h want 0", r); end
    n_tests++;
    if ({busy, ready, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/ready/div_zero got %b want 000", {busy, ready, div_zero});
    end
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    int bc;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    predict(100, 7, 1'b0);
    accept(100, 7);
    wait_done(-1, lat, bc);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL basic_q: got %0d want %0d", q, eq); end
    n_tests++;
    if (r !== er) begin n_fail++; $display("FAIL basic_r: got %0d want %0d", r, er); end
    n_tests++;
    if (div_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", div_zero); end
    n_tests++;
    if (lat != W + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
    n_tests++;
    if (bc != W + 1) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W + 1); end
    @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_pulse: got %b want 0", ready); end
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL basic_q_hold: got %0d want %0d", q, eq); end
  endtask

  task automatic test_div_zero();
    int lat;
    int bc;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    predict(32'h0000_1234, 0, 1'b0);
    accept(32'h0000_1234, 0);
    wait_done(-1, lat, bc);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL dz_q: got %h want %h", q, eq); end
    n_tests++;
    if (r !== er) begin n_fail++; $display("FAIL dz_r: got %h want %h", r, er); end
    n_tests++;
    if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    n_tests++;
    if (lat != 0) begin n_fail++; $display("FAIL dz_latency: got %0d want 0", lat); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    n_tests++;
    if ({ready, busy, div_zero} !== 3'b001) begin
      n_fail++;
      $display("FAIL dz_after: ready/busy/div_zero got %b want 001", {ready, busy, div_zero});
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] xs[2];
    logic [W-1:0] ys[2];
    int lat;
    int bc;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    xs[0] = 32'hFFFF_FFFF; ys[0] = 32'd1;
    xs[1] = 32'd5;         ys[1] = 32'd9;
    for (int i = 0; i < 2; i++) begin
      predict(xs[i], ys[i], 1'b0);
      accept(xs[i], ys[i]);
      wait_done(-1, lat, bc);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      n_tests++;
      if (q !== eq || r !== er || div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL edge_%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=0", i, q, r, div_zero, eq, er);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int bc;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    predict(100, 7, 1'b0);
    accept(100, 7);
    wait_done(10, lat, bc);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    n_tests++;
    if (q !== eq || r !== er) begin
      n_fail++;
      $display("FAIL ignore_start: got q=%0d r=%0d want q=%0d r=%0d", q, r, eq, er);
    end
    n_tests++;
    if (lat != W + 1) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat, W + 1); end
  endtask

  task automatic test_abort();
    int lat;
    int bc;
    int seen;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    accept(100, 7);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    clrn = 1'b0;
    #1;
    n_tests++;
    if ({q, r} !== '0 || {busy, ready, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_clear: got q=%h r=%h flags=%b want all 0", q, r, {busy, ready, div_zero});
    end
    @(posedge clk);
    #1;
    clrn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d active cycles want 0", seen); end
    predict(9, 3, 1'b0);
    accept(9, 3);
    wait_done(-1, lat, bc);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    n_tests++;
    if (q !== eq || r !== er) begin
      n_fail++;
      $display("FAIL abort_fresh: got q=%0d r=%0d want q=%0d r=%0d", q, r, eq, er);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    logic [W-1:0] eq1;
    logic [W-1:0] er1;
    logic [W-1:0] eq2;
    logic [W-1:0] er2;
    logic [W-1:0] x2;
    logic [W-1:0] y2;
    predict(32'd1000, 32'd33, 1'b0);
    eq1 = exp_q.pop_front();
    er1 = exp_q.pop_front();
    x2 = $urandom;
    y2 = $urandom_range(1, 1000);
    predict(x2, y2, 1'b0);
    eq2 = exp_q.pop_front();
    er2 = exp_q.pop_front();
    accept(32'd1000, 32'd33);
    wait_done(-1, lat, bc);
    n_tests++;
    if (q !== eq1 || r !== er1) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%0d r=%0d want q=%0d r=%0d", q, r, eq1, er1);
    end
    // Start again in the ready cycle; it must be taken on the very next edge.
    accept(x2, y2);
    n_tests++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy/ready got %b%b want 10", busy, ready);
    end
    n_tests++;
    if (q !== eq1) begin n_fail++; $display("FAIL b2b_hold: got %0d want %0d", q, eq1); end
    wait_done(-1, lat, bc);
    n_tests++;
    if (q !== eq2 || r !== er2 || lat != W + 1) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", q, r, lat, eq2, er2, W + 1);
    end
  endtask

  task automatic test_random();
    int lat;
    int bc;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic sg;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = $urandom;
        1: y = $urandom_range(1, 255);
        2: y = '0;
        3: y = $urandom_range(0, 15);
        default: y = x + W'($urandom_range(0, 3));
      endcase
      sg = 1'b0;
`ifdef DIV_NR_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
      sign = sg;
`endif
      predict(x, y, sg);
      accept(x, y);
      wait_done(-1, lat, bc);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      n_tests++;
      if (q !== eq || r !== er || div_zero !== (y == '0) || lat != ((y == '0) ? 0 : W + 1)) begin
        n_fail++;
        $display("FAIL rand_%0d: a=%h b=%h s=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b",
                 i, x, y, sg, q, r, div_zero, lat, eq, er, (y == '0));
      end
    end
`ifdef DIV_NR_SIGNED_EN
    sign = 1'b0;
`endif
  endtask

`ifdef DIV_NR_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] xs[3];
    logic [W-1:0] ys[3];
    int lat;
    int bc;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    xs[0] = -32'sd7;       ys[0] = 32'd2;
    xs[1] = 32'h8000_0000; ys[1] = 32'hFFFF_FFFF;
    xs[2] = 32'd100;       ys[2] = -32'sd7;
    sign = 1'b1;
    for (int i = 0; i < 3; i++) begin
      predict(xs[i], ys[i], 1'b1);
      accept(xs[i], ys[i]);
      wait_done(-1, lat, bc);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      n_tests++;
      if (q !== eq || r !== er || lat != W + 1) begin
        n_fail++;
        $display("FAIL signed_%0d: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", i, q, r, lat, eq, er, W + 1);
      end
    end
    sign = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_edges();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef DIV_NR_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
